id_ex_stage: RTL and testbench

Decode stage and ID/EX pipeline register of the 5-stage forwarding MIPS pipeline. It drives the register-file read addresses (Ra/Rb) and consumes the asynchronous read buses (Ba/Bb). It also decodes the instruction, bypasses same-cycle WB writes, and detects load-use hazards. The registered operands and control it produces feed the EX stage and the EX forwarding unit.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/id_ex_stage_if.sv | 48 ++++
 rtl/main_decoder.sv | 72 +++++++
 rtl/id_ex_stage.sv | 130 +++++++++++++
 tb/tb_id_ex_stage.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: opcodes, R-type functs, ALU ops
// and the control bundle produced by the main decoder.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_NOR = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;

   typedef enum logic [1:0] {
      DST_NONE,
      DST_RD,
      DST_RT
   } dst_sel_e;

   typedef struct packed {
      logic       valid;
      logic       regwr;
      logic       memrd;
      logic       memwr;
      logic       memtoreg;
      logic       alusrc;
      logic       branch;
      logic       uses_rt;
      dst_sel_e   dst_sel;
      logic [3:0] aluop;
   } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between IF/ID, register file, WB and the ID/EX register.
// master drives the ID-side inputs; slave is the decode stage itself.
interface id_ex_stage_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5
);
   logic [31:0]   instr_id;
   logic [DW-1:0] pc4_id;
   logic          valid_id;
   logic [AW-1:0] Ra;
   logic [AW-1:0] Rb;
   logic [DW-1:0] Ba;
   logic [DW-1:0] Bb;
   logic [AW-1:0] Rw_wb;
   logic [DW-1:0] Bw_wb;
   logic          Regwr_wb;
   logic          flush;
   logic          stall;
   logic          valid_ex;
   logic [DW-1:0] pc4_ex;
   logic [DW-1:0] rs_val_ex;
   logic [DW-1:0] rt_val_ex;
   logic [DW-1:0] imm_ex;
   logic [AW-1:0] rs_ex;
   logic [AW-1:0] rt_ex;
   logic [AW-1:0] dst_ex;
   logic          regwr_ex;
   logic          memrd_ex;
   logic          memwr_ex;
   logic          memtoreg_ex;
   logic          alusrc_ex;
   logic          branch_ex;
   logic [3:0]    aluop_ex;

   modport master (
      output instr_id, pc4_id, valid_id, Ba, Bb, Rw_wb, Bw_wb, Regwr_wb, flush,
      input  Ra, Rb, stall, valid_ex, pc4_ex, rs_val_ex, rt_val_ex, imm_ex,
             rs_ex, rt_ex, dst_ex, regwr_ex, memrd_ex, memwr_ex, memtoreg_ex,
             alusrc_ex, branch_ex, aluop_ex
   );

   modport slave (
      input  instr_id, pc4_id, valid_id, Ba, Bb, Rw_wb, Bw_wb, Regwr_wb, flush,
      output Ra, Rb, stall, valid_ex, pc4_ex, rs_val_ex, rt_val_ex, imm_ex,
             rs_ex, rt_ex, dst_ex, regwr_ex, memrd_ex, memwr_ex, memtoreg_ex,
             alusrc_ex, branch_ex, aluop_ex
   );
endinterface

// File: rtl/main_decoder.sv
// Combinational main decoder: opcode/funct to control bundle.
// Unsupported encodings decode to an all-zero (bubble) bundle.
module main_decoder
   import mips_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output ctrl_t      ctrl,
   output logic       imm_zext
);

   always_comb begin
      ctrl     = '0;
      imm_zext = 1'b0;
      case (op)
         OP_RTYPE: begin
            ctrl.valid   = 1'b1;
            ctrl.regwr   = 1'b1;
            ctrl.uses_rt = 1'b1;
            ctrl.dst_sel = DST_RD;
            case (funct)
               FN_ADD:  ctrl.aluop = ALU_ADD;
               FN_SUB:  ctrl.aluop = ALU_SUB;
               FN_AND:  ctrl.aluop = ALU_AND;
               FN_OR:   ctrl.aluop = ALU_OR;
               FN_NOR:  ctrl.aluop = ALU_NOR;
               FN_SLT:  ctrl.aluop = ALU_SLT;
               default: ctrl = '0;
            endcase
         end
         OP_LW: begin
            ctrl.valid    = 1'b1;
            ctrl.regwr    = 1'b1;
            ctrl.memrd    = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.dst_sel  = DST_RT;
            ctrl.aluop    = ALU_ADD;
         end
         OP_SW: begin
            ctrl.valid   = 1'b1;
            ctrl.memwr   = 1'b1;
            ctrl.alusrc  = 1'b1;
            ctrl.uses_rt = 1'b1;
            ctrl.dst_sel = DST_RT;
            ctrl.aluop   = ALU_ADD;
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
            ctrl.valid   = 1'b1;
            ctrl.regwr   = 1'b1;
            ctrl.alusrc  = 1'b1;
            ctrl.dst_sel = DST_RT;
            case (op)
               OP_SLTI: ctrl.aluop = ALU_SLT;
               OP_ANDI: ctrl.aluop = ALU_AND;
               OP_ORI:  ctrl.aluop = ALU_OR;
               default: ctrl.aluop = ALU_ADD;
            endcase
            imm_zext = (op == OP_ANDI) || (op == OP_ORI);
         end
         OP_BEQ: begin
            ctrl.valid   = 1'b1;
            ctrl.branch  = 1'b1;
            ctrl.uses_rt = 1'b1;
            ctrl.dst_sel = DST_RT;
            ctrl.aluop   = ALU_SUB;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX register: register-file read addressing, WB bypass,
// load-use hazard detection and the registered operands/control for EX.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   id_ex_stage_if.slave  bus
);

   typedef struct packed {
      logic          valid;
      logic [DW-1:0] pc4;
      logic [DW-1:0] rs_val;
      logic [DW-1:0] rt_val;
      logic [DW-1:0] imm;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] dst;
      logic          regwr;
      logic          memrd;
      logic          memwr;
      logic          memtoreg;
      logic          alusrc;
      logic          branch;
      logic [3:0]    aluop;
   } idex_t;

   idex_t         idex_d, idex_q;
   ctrl_t         ctrl;
   logic          imm_zext;
   logic [AW-1:0] rs_id, rt_id, rd_id, dst_id;
   logic [DW-1:0] rs_val, rt_val, imm_val;
   logic          load_use, stall, bubble;

   main_decoder u_dec (
      .op       (bus.instr_id[31:26]),
      .funct    (bus.instr_id[5:0]),
      .ctrl     (ctrl),
      .imm_zext (imm_zext)
   );

   assign rs_id = bus.instr_id[25:21];
   assign rt_id = bus.instr_id[20:16];
   assign rd_id = bus.instr_id[15:11];

   // The register file writes on the edge but reads asynchronously, so a
   // same-cycle WB write must be bypassed into the operand latched here.
   always_comb begin
      rs_val = bus.Ba;
      if (rs_id == '0)
         rs_val = '0;
      else if (bus.Regwr_wb && (bus.Rw_wb != '0) && (bus.Rw_wb == rs_id))
         rs_val = bus.Bw_wb;

      rt_val = bus.Bb;
      if (rt_id == '0)
         rt_val = '0;
      else if (bus.Regwr_wb && (bus.Rw_wb != '0) && (bus.Rw_wb == rt_id))
         rt_val = bus.Bw_wb;
   end

   always_comb begin
      imm_val = imm_zext ? {{(DW-16){1'b0}}, bus.instr_id[15:0]}
                         : {{(DW-16){bus.instr_id[15]}}, bus.instr_id[15:0]};
      case (ctrl.dst_sel)
         DST_RD:  dst_id = rd_id;
         DST_RT:  dst_id = rt_id;
         default: dst_id = '0;
      endcase
   end

   assign load_use = bus.valid_id && idex_q.valid && idex_q.memrd &&
                     (idex_q.rt != '0) &&
                     ((idex_q.rt == rs_id) || (ctrl.uses_rt && (idex_q.rt == rt_id)));
   // A flushed ID instruction is discarded, so it can never cause a stall.
   assign stall  = load_use && !bus.flush;
   assign bubble = bus.flush || stall || !bus.valid_id || !ctrl.valid;

   always_comb begin
      idex_d = '0;
      if (!bubble) begin
         idex_d.valid    = 1'b1;
         idex_d.pc4      = bus.pc4_id;
         idex_d.rs_val   = rs_val;
         idex_d.rt_val   = rt_val;
         idex_d.imm      = imm_val;
         idex_d.rs       = rs_id;
         idex_d.rt       = rt_id;
         idex_d.dst      = dst_id;
         idex_d.regwr    = ctrl.regwr;
         idex_d.memrd    = ctrl.memrd;
         idex_d.memwr    = ctrl.memwr;
         idex_d.memtoreg = ctrl.memtoreg;
         idex_d.alusrc   = ctrl.alusrc;
         idex_d.branch   = ctrl.branch;
         idex_d.aluop    = ctrl.aluop;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         idex_q <= '0;
      else
         idex_q <= idex_d;
   end

   assign bus.Ra          = rs_id;
   assign bus.Rb          = rt_id;
   assign bus.stall       = stall;
   assign bus.valid_ex    = idex_q.valid;
   assign bus.pc4_ex      = idex_q.pc4;
   assign bus.rs_val_ex   = idex_q.rs_val;
   assign bus.rt_val_ex   = idex_q.rt_val;
   assign bus.imm_ex      = idex_q.imm;
   assign bus.rs_ex       = idex_q.rs;
   assign bus.rt_ex       = idex_q.rt;
   assign bus.dst_ex      = idex_q.dst;
   assign bus.regwr_ex    = idex_q.regwr;
   assign bus.memrd_ex    = idex_q.memrd;
   assign bus.memwr_ex    = idex_q.memwr;
   assign bus.memtoreg_ex = idex_q.memtoreg;
   assign bus.alusrc_ex   = idex_q.alusrc;
   assign bus.branch_ex   = idex_q.branch;
   assign bus.aluop_ex    = idex_q.aluop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, WB bypass, load-use stall,
// flush priority, immediate extension and asynchronous reset.
module tb_id_ex_stage;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   id_ex_stage_if #(.DW(32), .AW(5)) bus ();

   id_ex_stage #(.DW(32), .AW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] ba, input logic [31:0] bb);
      bus.instr_id = ins;
      bus.valid_id = 1'b1;
      bus.Ba       = ba;
      bus.Bb       = bb;
      #1;
   endtask

   function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'b00000, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

   initial begin
      // Reset held with random inputs
      reset        = 1'b0;
      bus.instr_id = $urandom;
      bus.pc4_id   = $urandom;
      bus.valid_id = 1'b1;
      bus.Ba       = $urandom;
      bus.Bb       = $urandom;
      bus.Rw_wb    = 5'($urandom);
      bus.Bw_wb    = $urandom;
      bus.Regwr_wb = 1'b1;
      bus.flush    = 1'b0;
      repeat (3) tick();
      check("rst_valid",  32'(bus.valid_ex), 32'd0);
      check("rst_pc4",    bus.pc4_ex, 32'd0);
      check("rst_rsval",  bus.rs_val_ex, 32'd0);
      check("rst_rtval",  bus.rt_val_ex, 32'd0);
      check("rst_imm",    bus.imm_ex, 32'd0);
      check("rst_regs",   32'({bus.rs_ex, bus.rt_ex, bus.dst_ex}), 32'd0);
      check("rst_ctrl",   32'({bus.regwr_ex, bus.memrd_ex, bus.memwr_ex, bus.memtoreg_ex,
                               bus.alusrc_ex, bus.branch_ex, bus.aluop_ex}), 32'd0);
      check("rst_stall",  32'(bus.stall), 32'd0);

      // First instruction: add $3,$1,$2
      reset        = 1'b1;
      bus.Regwr_wb = 1'b0;
      bus.pc4_id   = 32'h0000_0104;
      issue(r_ins(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
      check("ra", 32'(bus.Ra), 32'd1);
      check("rb", 32'(bus.Rb), 32'd2);
      tick();
      check("add_valid", 32'(bus.valid_ex), 32'd1);
      check("add_rsval", bus.rs_val_ex, 32'd5);
      check("add_rtval", bus.rt_val_ex, 32'd7);
      check("add_dst",   32'(bus.dst_ex), 32'd3);
      check("add_aluop", 32'(bus.aluop_ex), 32'd0);
      check("add_regwr", 32'(bus.regwr_ex), 32'd1);
      check("add_alusrc", 32'(bus.alusrc_ex), 32'd0);
      check("add_pc4",   bus.pc4_ex, 32'h0000_0104);
      check("add_rsrt",  32'({bus.rs_ex, bus.rt_ex}), 32'({5'd1, 5'd2}));
      check("add_imm",   bus.imm_ex, 32'h0000_1820);

      // R-type funct table
      for (int i = 0; i < 6; i++) begin
         issue(r_ins(5'd8, 5'd9, 5'd10, fn_tab[i]), 32'(i), 32'd0);
         tick();
         check($sformatf("rtype_aluop%0d", i), 32'(bus.aluop_ex), 32'(i));
         check($sformatf("rtype_valid%0d", i), 32'(bus.valid_ex), 32'd1);
      end
      issue(r_ins(5'd8, 5'd9, 5'd10, 6'h21), 32'd1, 32'd2);
      tick();
      check("badfn_valid", 32'(bus.valid_ex), 32'd0);
      check("badfn_regwr", 32'(bus.regwr_ex), 32'd0);

      // WB bypass
      bus.Regwr_wb = 1'b1;
      bus.Rw_wb    = 5'd1;
      bus.Bw_wb    = 32'h0000_DEAD;
      issue(r_ins(5'd1, 5'd2, 5'd3, 6'h20), 32'd0, 32'd7);
      tick();
      check("byp_rs", bus.rs_val_ex, 32'h0000_DEAD);
      check("byp_rs_rt", bus.rt_val_ex, 32'd7);
      bus.Rw_wb = 5'd0;
      issue(r_ins(5'd1, 5'd2, 5'd3, 6'h20), 32'h1234, 32'd7);
      tick();
      check("byp_r0_rs", bus.rs_val_ex, 32'h1234);
      bus.Rw_wb = 5'd2;
      issue(r_ins(5'd1, 5'd2, 5'd3, 6'h20), 32'h1234, 32'd7);
      tick();
      check("byp_rt", bus.rt_val_ex, 32'h0000_DEAD);
      bus.Regwr_wb = 1'b0;
      issue(r_ins(5'd1, 5'd2, 5'd3, 6'h20), 32'h1234, 32'h5678);
      tick();
      check("byp_off_rt", bus.rt_val_ex, 32'h5678);
      issue(r_ins(5'd0, 5'd2, 5'd3, 6'h20), 32'h55, 32'h5678);
      tick();
      check("reg0_rs", bus.rs_val_ex, 32'd0);

      // Load-use: lw $4 then add $5,$4,$6
      issue(i_ins(6'h23, 5'd1, 5'd4, 16'h0), 32'h100, 32'd0);
      check("lw_nostall", 32'(bus.stall), 32'd0);
      tick();
      check("lw_ctrl", 32'({bus.regwr_ex, bus.memrd_ex, bus.memtoreg_ex, bus.alusrc_ex}), 32'hF);
      check("lw_dst", 32'(bus.dst_ex), 32'd4);
      issue(r_ins(5'd4, 5'd6, 5'd5, 6'h20), 32'h44, 32'h66);
      check("lu_stall", 32'(bus.stall), 32'd1);
      tick();
      check("lu_bubble", 32'(bus.valid_ex), 32'd0);
      check("lu_bub_ctrl", 32'({bus.regwr_ex, bus.memrd_ex}), 32'd0);
      check("lu_stall_end", 32'(bus.stall), 32'd0);
      tick();
      check("lu_add_valid", 32'(bus.valid_ex), 32'd1);
      check("lu_add_dst", 32'(bus.dst_ex), 32'd5);
      check("lu_add_rs", bus.rs_val_ex, 32'h44);

      // lw $4 then sw $4,8($1)
      issue(i_ins(6'h23, 5'd1, 5'd4, 16'h0), 32'h100, 32'd0);
      tick();
      issue(i_ins(6'h2B, 5'd1, 5'd4, 16'h8), 32'h100, 32'h99);
      check("sw_stall", 32'(bus.stall), 32'd1);
      tick();
      check("sw_bubble", 32'({bus.valid_ex, bus.memwr_ex}), 32'd0);
      tick();
      check("sw_ctrl", 32'({bus.valid_ex, bus.memwr_ex, bus.alusrc_ex, bus.regwr_ex}), 32'hE);
      check("sw_imm", bus.imm_ex, 32'd8);

      // lw $4 then addi $7,$4,1
      issue(i_ins(6'h23, 5'd1, 5'd4, 16'h0), 32'h100, 32'd0);
      tick();
      issue(i_ins(6'h08, 5'd4, 5'd7, 16'h1), 32'h11, 32'd0);
      check("addi_stall", 32'(bus.stall), 32'd1);
      tick();
      check("addi_bubble", 32'(bus.valid_ex), 32'd0);
      tick();
      check("addi_ctrl", 32'({bus.valid_ex, bus.regwr_ex, bus.alusrc_ex}), 32'h7);
      check("addi_dst", 32'(bus.dst_ex), 32'd7);

      // lw $4 then beq $1,$4 (rt is a source)
      issue(i_ins(6'h23, 5'd1, 5'd4, 16'h0), 32'h100, 32'd0);
      tick();
      issue(i_ins(6'h04, 5'd1, 5'd4, 16'hFFFE), 32'h1, 32'h2);
      check("beq_stall", 32'(bus.stall), 32'd1);
      tick();
      tick();
      check("beq_ctrl", 32'({bus.valid_ex, bus.branch_ex, bus.regwr_ex}), 32'h6);
      check("beq_aluop", 32'(bus.aluop_ex), 32'd1);
      check("beq_imm", bus.imm_ex, 32'hFFFF_FFFE);

      // No false stall: lw $0 then add $5,$0,$6
      issue(i_ins(6'h23, 5'd1, 5'd0, 16'h0), 32'h100, 32'd0);
      tick();
      issue(r_ins(5'd0, 5'd6, 5'd5, 6'h20), 32'h0, 32'h66);
      check("r0_nostall", 32'(bus.stall), 32'd0);
      tick();
      check("r0_valid", 32'(bus.valid_ex), 32'd1);

      // No false stall: lw $4 then addi $4,$8,1
      issue(i_ins(6'h23, 5'd1, 5'd4, 16'h0), 32'h100, 32'd0);
      tick();
      issue(i_ins(6'h08, 5'd8, 5'd4, 16'h1), 32'h80, 32'd0);
      check("rtdst_nostall", 32'(bus.stall), 32'd0);
      tick();
      check("rtdst_valid", 32'(bus.valid_ex), 32'd1);
      check("rtdst_dst", 32'(bus.dst_ex), 32'd4);

      // Invalid IF/ID never stalls and yields a bubble
      issue(i_ins(6'h23, 5'd1, 5'd4, 16'h0), 32'h100, 32'd0);
      tick();
      issue(r_ins(5'd4, 5'd6, 5'd5, 6'h20), 32'h44, 32'h66);
      bus.valid_id = 1'b0;
      #1;
      check("novalid_stall", 32'(bus.stall), 32'd0);
      tick();
      check("novalid_bubble", 32'(bus.valid_ex), 32'd0);

      // Flush overrides a load-use stall
      issue(i_ins(6'h23, 5'd1, 5'd4, 16'h0), 32'h100, 32'd0);
      tick();
      issue(r_ins(5'd4, 5'd6, 5'd5, 6'h20), 32'h44, 32'h66);
      bus.flush = 1'b1;
      #1;
      check("flush_stall", 32'(bus.stall), 32'd0);
      tick();
      check("flush_bubble", 32'({bus.valid_ex, bus.regwr_ex}), 32'd0);
      check("flush_rsval", bus.rs_val_ex, 32'd0);
      bus.flush = 1'b0;

      // Immediate extension
      issue(i_ins(6'h0C, 5'd1, 5'd2, 16'h8000), 32'd0, 32'd0);
      tick();
      check("andi_imm", bus.imm_ex, 32'h0000_8000);
      check("andi_aluop", 32'(bus.aluop_ex), 32'd2);
      issue(i_ins(6'h0D, 5'd1, 5'd2, 16'h8001), 32'd0, 32'd0);
      tick();
      check("ori_imm", bus.imm_ex, 32'h0000_8001);
      check("ori_aluop", 32'(bus.aluop_ex), 32'd3);
      issue(i_ins(6'h08, 5'd1, 5'd2, 16'h8000), 32'd0, 32'd0);
      tick();
      check("addi_imm", bus.imm_ex, 32'hFFFF_8000);
      issue(i_ins(6'h0A, 5'd1, 5'd2, 16'hFFFF), 32'd0, 32'd0);
      tick();
      check("slti_imm", bus.imm_ex, 32'hFFFF_FFFF);
      check("slti_aluop", 32'(bus.aluop_ex), 32'd5);
      issue(i_ins(6'h3F, 5'd1, 5'd2, 16'h1234), 32'd0, 32'd0);
      tick();
      check("illegal_valid", 32'(bus.valid_ex), 32'd0);
      check("illegal_ctrl", 32'({bus.regwr_ex, bus.memwr_ex, bus.branch_ex}), 32'd0);

      // Asynchronous reset mid-cycle
      bus.pc4_id = 32'h0000_0200;
      issue(r_ins(5'd1, 5'd2, 5'd3, 6'h20), 32'd5, 32'd7);
      tick();
      check("pre_arst_valid", 32'(bus.valid_ex), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_valid", 32'(bus.valid_ex), 32'd0);
      check("arst_pc4", bus.pc4_ex, 32'd0);
      check("arst_regwr", 32'(bus.regwr_ex), 32'd0);
      reset = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
